// File: rtl/bus_a_arbiter.sv
// Round-robin owner arbiter for the 16-bit bus A source mux with registered grant/select.
// Optional hold timeout (forced release when others wait) is built when BUS_A_TIMEOUT_EN is defined.
module bus_a_arbiter #(
  parameter int NREQ     = 4,
  parameter int HOLD_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [3*NREQ-1:0] src,
  input  logic [NREQ-1:0]   last,
  output logic [NREQ-1:0]   gnt,
  output logic [2:0]        sel,
  output logic              bus_valid,
  output logic              busy,
  output logic              timeout_evt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [2:0] SEL_NONE  = 3'b111;
  localparam logic [2:0] SEL_LEGAL = 3'b100;

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("bus_a_arbiter: NREQ must be in 2..8");
  end
  if (HOLD_MAX < 1) begin : g_bad_hold
    $error("bus_a_arbiter: HOLD_MAX must be at least 1");
  end

  typedef enum logic {IDLE, OWN} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [2:0]      sel_q, sel_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;

  logic [NREQ-1:0] cand;
  logic            found;
  logic [PW-1:0]   win;
  logic [2:0]      win_src;
  logic [2:0]      own_src;
  logic            own_req;
  logic            own_last;
  logic            to_hit;
  logic            release_own;

  // While owning, ptr_q is the owner index.
  always_comb begin
    own_req  = 1'b0;
    own_last = 1'b0;
    own_src  = SEL_NONE;
    for (int i = 0; i < NREQ; i++) begin
      if (ptr_q == PW'(i)) begin
        own_req  = req[i];
        own_last = last[i];
        own_src  = src[3*i +: 3];
      end
    end
  end

  // The current owner is excluded so it only regains the bus after all other waiters.
  assign cand = (state_q == OWN) ? (req & ~gnt_q) : req;

  always_comb begin
    int idx;
    idx     = 0;
    found   = 1'b0;
    win     = ptr_q;
    win_src = SEL_NONE;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && cand[idx]) begin
        found   = 1'b1;
        win     = PW'(idx);
        win_src = src[3*idx +: 3];
      end
    end
  end

`ifdef BUS_A_TIMEOUT_EN
  localparam int CW = $clog2(HOLD_MAX + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tev_q, tev_d;

  // Fires on the edge where the counter would reach HOLD_MAX, giving the owner HOLD_MAX cycles.
  assign to_hit      = (state_q == OWN) && (cand != '0) && (cnt_q >= CW'(HOLD_MAX - 1));
  assign timeout_evt = tev_q;
`else
  assign to_hit      = 1'b0;
  assign timeout_evt = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    valid_d     = valid_q;
    busy_d      = busy_q;
    release_own = !own_req || own_last || to_hit;
`ifdef BUS_A_TIMEOUT_EN
    tev_d = 1'b0;
    cnt_d = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = OWN;
          ptr_d      = win;
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          sel_d      = (win_src <= SEL_LEGAL) ? win_src : SEL_NONE;
          valid_d    = (win_src <= SEL_LEGAL);
          busy_d     = 1'b1;
`ifdef BUS_A_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end
      OWN: begin
        if (release_own) begin
`ifdef BUS_A_TIMEOUT_EN
          tev_d = to_hit && own_req && !own_last;
          cnt_d = '0;
`endif
          if (found) begin
            ptr_d      = win;
            gnt_d      = '0;
            gnt_d[win] = 1'b1;
            sel_d      = (win_src <= SEL_LEGAL) ? win_src : SEL_NONE;
            valid_d    = (win_src <= SEL_LEGAL);
            busy_d     = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            sel_d   = SEL_NONE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
          end
        end else begin
          sel_d   = (own_src <= SEL_LEGAL) ? own_src : SEL_NONE;
          valid_d = (own_src <= SEL_LEGAL);
`ifdef BUS_A_TIMEOUT_EN
          if (cnt_q != CW'(HOLD_MAX)) cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        sel_d   = SEL_NONE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= PW'(NREQ - 1);
      gnt_q   <= '0;
      sel_q   <= SEL_NONE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

`ifdef BUS_A_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tev_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tev_q <= tev_d;
    end
  end
`endif

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign bus_valid = valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bus_a_arbiter.sv
// Bench for bus_a_arbiter: directed scenarios plus random traffic against an owner/pointer model.
// Honours BUS_A_TIMEOUT_EN the same way the design does.
module tb_bus_a_arbiter;

  localparam int NREQ     = 4;
  localparam int HOLD_MAX = 15;
  localparam int OW       = NREQ + 6;
`ifdef BUS_A_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req   = '0;
  logic [3*NREQ-1:0] src   = '0;
  logic [NREQ-1:0]   last  = '0;
  logic [NREQ-1:0]   gnt;
  logic [2:0]        sel;
  logic              bus_valid;
  logic              busy;
  logic              timeout_evt;

  bus_a_arbiter #(.NREQ(NREQ), .HOLD_MAX(HOLD_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .src(src), .last(last),
    .gnt(gnt), .sel(sel), .bus_valid(bus_valid), .busy(busy), .timeout_evt(timeout_evt)
  );

  always #5 clk = ~clk;

  // Model: current owner (-1 = none), round-robin pointer, cycles held.
  int m_owner = -1;
  int m_ptr   = NREQ - 1;
  int m_held  = 0;
  bit m_tev   = 1'b0;
  logic [OW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  function automatic int rr_pick(logic [NREQ-1:0] mask, int from);
    for (int k = 1; k <= NREQ; k++) begin
      if (mask[(from + k) % NREQ]) return (from + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [OW-1:0] model_out();
    logic [2:0]      code;
    logic [NREQ-1:0] g;
    if (m_owner < 0) return {{NREQ{1'b0}}, 3'b111, 1'b0, 1'b0, m_tev};
    code = src[3*m_owner +: 3];
    g    = '0;
    g[m_owner] = 1'b1;
    if (code <= 3'd4) return {g, code, 1'b1, 1'b1, m_tev};
    return {g, 3'b111, 1'b0, 1'b1, m_tev};
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = NREQ - 1;
    m_held  = 0;
    m_tev   = 1'b0;
    exp_q.push_back({{NREQ{1'b0}}, 3'b111, 1'b0, 1'b0, 1'b0});
  endtask

  task automatic model_step();
    logic [NREQ-1:0] others;
    bit hit;
    int w;
    m_tev = 1'b0;
    if (m_owner < 0) begin
      w = rr_pick(req, m_ptr);
      if (w >= 0) begin
        m_owner = w;
        m_ptr   = w;
        m_held  = 0;
      end
    end else begin
      others = req;
      others[m_owner] = 1'b0;
      hit = TO_EN && (others != '0) && (m_held + 1 >= HOLD_MAX);
      if (!req[m_owner] || last[m_owner] || hit) begin
        m_tev   = hit && req[m_owner] && !last[m_owner];
        w       = rr_pick(others, m_owner);
        m_owner = w;
        if (w >= 0) m_ptr = w;
        m_held  = 0;
      end else begin
        m_held = (m_held < HOLD_MAX) ? m_held + 1 : HOLD_MAX;
      end
    end
    exp_q.push_back(model_out());
  endtask

  task automatic cycle_compare();
    logic [OW-1:0] e;
    logic [OW-1:0] got;
    got = {gnt, sel, bus_valid, busy, timeout_evt};
    e   = exp_q.pop_front();
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL cycle_check cyc=%0d {gnt,sel,bus_valid,busy,timeout_evt} got=%b required=%b",
               cyc, got, e);
    end
  endtask

  // One clock: model sees the inputs present at the edge, outputs checked 1 time unit later.
  task automatic step();
    @(posedge clk);
    cyc++;
    if (!rst_n) model_reset();
    else model_step();
    #1;
    cycle_compare();
    #1;
  endtask

  task automatic reset_now();
    rst_n = 1'b0;
    model_reset();
    #1;
    cycle_compare();
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h required=%0h", name, got, want);
    end
  endtask

  task automatic do_reset();
    req  = '0;
    last = '0;
    src  = '0;
    reset_now();
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [NREQ-1:0] seq [5];
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;

    // Reset values and single requester grant/release.
    repeat (2) step();
    rst_n = 1'b1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_sel", 32'(sel), 32'h7);
    chk("rst_bv_busy_tev", {29'd0, bus_valid, busy, timeout_evt}, 32'h0);
    req = 4'b0001;
    src[2:0] = 3'b010;
    step();
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_sel", 32'(sel), 32'h2);
    chk("t1_bv_busy", {30'd0, bus_valid, busy}, 32'h3);
    req = 4'b0000;
    step();
    chk("t1_rel_gnt", 32'(gnt), 32'h0);
    chk("t1_rel_sel", 32'(sel), 32'h7);
    chk("t1_rel_busy", 32'(busy), 32'h0);

    // All requesting, each owner ends on its first owned cycle.
    do_reset();
    req  = 4'b1111;
    last = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("t2_rr_%0d", i), 32'(gnt), 32'(seq[i]));
    end

    // Owner 1 changes source per cycle, then goes illegal and back.
    do_reset();
    req = 4'b0010;
    src[5:3] = 3'b000;
    step();
    chk("t3_gnt", 32'(gnt), 32'h2);
    chk("t3_sel0", 32'(sel), 32'h0);
    src[5:3] = 3'b011;
    step();
    chk("t3_sel1", 32'(sel), 32'h3);
    src[5:3] = 3'b100;
    step();
    chk("t3_sel2", 32'(sel), 32'h4);
    src[5:3] = 3'b110;
    step();
    chk("t4_ill_sel", 32'(sel), 32'h7);
    chk("t4_ill_bv", 32'(bus_valid), 32'h0);
    chk("t4_ill_gnt", 32'(gnt), 32'h2);
    src[5:3] = 3'b001;
    step();
    chk("t4_ok_sel", 32'(sel), 32'h1);
    chk("t4_ok_bv", 32'(bus_valid), 32'h1);

    // Hold timeout with a second waiter.
    do_reset();
    req = 4'b0001;
    step();
    req = 4'b0101;
`ifdef BUS_A_TIMEOUT_EN
    for (int i = 0; i < HOLD_MAX - 1; i++) begin
      step();
      chk("t5_hold", 32'(gnt), 32'h1);
    end
    step();
    chk("t5_handoff", 32'(gnt), 32'h4);
    chk("t5_tev", 32'(timeout_evt), 32'h1);
    step();
    chk("t5_tev_pulse", 32'(timeout_evt), 32'h0);
`else
    repeat (HOLD_MAX + 5) step();
    chk("t5_no_timeout_gnt", 32'(gnt), 32'h1);
    chk("t5_no_timeout_tev", 32'(timeout_evt), 32'h0);
`endif

    // Asynchronous reset mid-grant, then pointer restarts at 0.
    do_reset();
    req = 4'b0100;
    step();
    chk("t6_gnt", 32'(gnt), 32'h4);
    #3;
    reset_now();
    chk("t6_async_gnt", 32'(gnt), 32'h0);
    chk("t6_async_sel", 32'(sel), 32'h7);
    chk("t6_async_busy", 32'(busy), 32'h0);
    req = 4'b0110;
    #2;
    rst_n = 1'b1;
    step();
    chk("t6_after_gnt", 32'(gnt), 32'h2);

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        for (int i = 0; i < NREQ; i++) req[i] = ($urandom_range(0, 9) < 6);
      end
      for (int i = 0; i < NREQ; i++) begin
        last[i] = ($urandom_range(0, 9) == 0);
        src[3*i +: 3] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(5, 7))
                                                     : 3'($urandom_range(0, 4));
      end
      if ($urandom_range(0, 199) == 0) begin
        reset_now();
        #1;
        rst_n = 1'b1;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
